// File: rtl/sub_pipe_clk.sv
// sub_pipe_clk: two-stage pipelined subtractor, d = a - b - bi.
//
// The difference is formed as a + ~b + ~bi with a block carry-lookahead adder.
// Stage 1 computes the low half and registers its carry. Stage 2 completes the
// high half from that carry and registers the result and flags. A valid/ready
// handshake sits on both sides. The whole pipeline stalls in lockstep whenever
// a held result is not being consumed.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   operand set a/b/bi is valid this cycle
//   in_ready   out  operands are accepted this cycle
//   a          in   minuend   [WIDTH-1:0]
//   b          in   subtrahend [WIDTH-1:0]
//   bi         in   borrow in
//   out_valid  out  d/flags hold a valid result
//   out_ready  in   consumer accepts the result this cycle
//   d          out  difference modulo 2^WIDTH [WIDTH-1:0]
//   bo         out  borrow out, 1 iff a < b + bi (unsigned)
//   ovf        out  signed overflow of the subtraction
//   zero       out  1 iff d == 0

module sub_pipe_clk #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned HALF = WIDTH / 2;
    // 4-bit lookahead groups; the top group is zero-padded if HALF is not a multiple of 4.
    localparam int unsigned NG   = (HALF + 3) / 4;
    localparam int unsigned NB   = NG * 4;

    // Returns {carry_out, sum} of x + y + cin.
    function automatic logic [HALF:0] cla_add(
        input logic [HALF-1:0] x,
        input logic [HALF-1:0] y,
        input logic            cin
    );
        logic [NB-1:0]   g;
        logic [NB-1:0]   p;
        logic [NB:0]     c;
        logic [NG-1:0]   gg;
        logic [NG-1:0]   gp;
        logic [NG:0]     gc;
        logic [HALF-1:0] s;
        int unsigned     base;

        g = '0;
        p = '0;
        for (int unsigned i = 0; i < HALF; i++) begin
            g[i] = x[i] & y[i];
            p[i] = x[i] ^ y[i];
        end

        // Group generate/propagate.
        for (int unsigned j = 0; j < NG; j++) begin
            base  = 4 * j;
            gg[j] = g[base+3]
                  | (p[base+3] & g[base+2])
                  | (p[base+3] & p[base+2] & g[base+1])
                  | (p[base+3] & p[base+2] & p[base+1] & g[base]);
            gp[j] = p[base+3] & p[base+2] & p[base+1] & p[base];
        end

        // Carries into each group.
        gc[0] = cin;
        for (int unsigned j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end

        // Bit carries inside each group, expanded from the group carry-in.
        for (int unsigned j = 0; j < NG; j++) begin
            base      = 4 * j;
            c[base]   = gc[j];
            c[base+1] = g[base] | (p[base] & gc[j]);
            c[base+2] = g[base+1]
                      | (p[base+1] & g[base])
                      | (p[base+1] & p[base] & gc[j]);
            c[base+3] = g[base+2]
                      | (p[base+2] & g[base+1])
                      | (p[base+2] & p[base+1] & g[base])
                      | (p[base+2] & p[base+1] & p[base] & gc[j]);
        end
        c[NB] = gc[NG];

        for (int unsigned i = 0; i < HALF; i++) begin
            s[i] = p[i] ^ c[i];
        end

        // With padding, the real carry-out lives inside the top group.
        return {c[HALF], s};
    endfunction

    // Stage 1 registers
    logic            v1_q;
    logic [HALF-1:0] lo_q;
    logic            c16_q;
    logic [HALF-1:0] a_hi_q;
    logic [HALF-1:0] nb_hi_q;
    logic            a_msb_q;
    logic            b_msb_q;

    // Stage 2 registers
    logic             out_valid_q;
    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             ovf_q;
    logic             zero_q;

    logic             adv;
    logic [HALF:0]    lo_sum;
    logic [HALF:0]    hi_sum;
    logic [WIDTH-1:0] d_d;
    logic             bo_d;
    logic             ovf_d;
    logic             zero_d;

    // Both stages move together; a held result blocks everything behind it.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !reset;

    // Stage 1 datapath: low half of a + ~b + ~bi.
    assign lo_sum = cla_add(a[HALF-1:0], ~b[HALF-1:0], ~bi);

    // Stage 2 datapath: high half using the registered low-half carry.
    assign hi_sum = cla_add(a_hi_q, nb_hi_q, c16_q);

    always_comb begin
        d_d    = {hi_sum[HALF-1:0], lo_q};
        // No carry out of a + ~b + ~bi means the subtraction borrowed.
        bo_d   = !hi_sum[HALF];
        ovf_d  = (a_msb_q != b_msb_q) && (d_d[WIDTH-1] != a_msb_q);
        zero_d = (d_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q        <= 1'b0;
            lo_q        <= '0;
            c16_q       <= 1'b0;
            a_hi_q      <= '0;
            nb_hi_q     <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bo_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            // Bubbles still load the data registers; only the valid bit marks them.
            v1_q        <= in_valid;
            lo_q        <= lo_sum[HALF-1:0];
            c16_q       <= lo_sum[HALF];
            a_hi_q      <= a[WIDTH-1:HALF];
            nb_hi_q     <= ~b[WIDTH-1:HALF];
            a_msb_q     <= a[WIDTH-1];
            b_msb_q     <= b[WIDTH-1];
            out_valid_q <= v1_q;
            d_q         <= d_d;
            bo_q        <= bo_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bo        = bo_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
